// File: rtl/rx_pkt_pair_fifo.sv
// rtl/rx_pkt_pair_fifo.sv - paired status/data receive FIFO with frame commit/drop and phase ordering
module rx_pkt_pair_fifo #(
    parameter int unsigned C_DATA_WIDTH = 64,
    parameter int unsigned C_STS_WIDTH  = 32,
    parameter int unsigned C_DATA_AW    = 9,
    parameter int unsigned C_STS_AW     = 9,
    parameter int unsigned C_DATA_AFULL = 496,
    parameter int unsigned C_STS_AFULL  = 496,
    parameter int unsigned C_STS_FIRST  = 1
) (
    input  logic                      s2mm_clk,
    input  logic                      sys_rst,
    input  logic [C_DATA_WIDTH-1:0]   data_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] data_wkeep,
    input  logic                      data_wlast,
    input  logic                      data_wgood,
    input  logic                      data_wren,
    output logic                      data_afull,
    input  logic [C_STS_WIDTH-1:0]    sts_wdata,
    input  logic [C_STS_WIDTH/8-1:0]  sts_wkeep,
    input  logic                      sts_wlast,
    input  logic                      sts_wren,
    output logic                      sts_afull,
    output logic [C_DATA_WIDTH-1:0]   rxd_tdata,
    output logic [C_DATA_WIDTH/8-1:0] rxd_tkeep,
    output logic                      rxd_tlast,
    output logic                      rxd_tvalid,
    input  logic                      rxd_tready,
    output logic [C_STS_WIDTH-1:0]    rxs_tdata,
    output logic [C_STS_WIDTH/8-1:0]  rxs_tkeep,
    output logic                      rxs_tlast,
    output logic                      rxs_tvalid,
    input  logic                      rxs_tready,
    output logic [C_DATA_AW:0]        pkt_cnt,
    output logic [15:0]               drop_cnt
);
    localparam int unsigned DKW = C_DATA_WIDTH / 8;
    localparam int unsigned SKW = C_STS_WIDTH / 8;
    localparam int unsigned DEW = C_DATA_WIDTH + DKW + 1;
    localparam int unsigned SEW = C_STS_WIDTH + SKW + 1;
    localparam logic [C_DATA_AW:0] D_ONE = {{C_DATA_AW{1'b0}}, 1'b1};
    localparam logic [C_STS_AW:0]  S_ONE = {{C_STS_AW{1'b0}}, 1'b1};

    typedef enum logic {PH_STS, PH_DATA} phase_t;
    localparam phase_t PH_RESET = (C_STS_FIRST != 0) ? PH_STS : PH_DATA;

    logic [DEW-1:0] dmem [2**C_DATA_AW];
    logic [SEW-1:0] smem [2**C_STS_AW];

    logic [C_DATA_AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [C_DATA_AW:0] pkt_cnt_q, pkt_cnt_d, data_occ;
    logic [C_STS_AW:0]  swr_ptr_q, swr_ptr_d, srd_ptr_q, srd_ptr_d, sts_occ;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               ovf_q, ovf_d, data_afull_q, data_afull_d, sts_afull_q, sts_afull_d;
    phase_t             phase_q, phase_d;

    logic data_full, sts_full, data_we, sts_we, ovf_now, commit, drop;
    logic rxd_hs, rxs_hs, rd_last;
    logic [DEW-1:0] drd;
    logic [SEW-1:0] srd;

    assign drd        = dmem[rd_ptr_q[C_DATA_AW-1:0]];
    assign srd        = smem[srd_ptr_q[C_STS_AW-1:0]];
    assign rxd_tdata  = drd[C_DATA_WIDTH-1:0];
    assign rxd_tkeep  = drd[C_DATA_WIDTH +: DKW];
    assign rxd_tlast  = drd[DEW-1];
    assign rxs_tdata  = srd[C_STS_WIDTH-1:0];
    assign rxs_tkeep  = srd[C_STS_WIDTH +: SKW];
    assign rxs_tlast  = srd[SEW-1];
    // Read side only ever sees committed data; valid is gated by reset so it is low throughout reset.
    assign rxd_tvalid = !sys_rst && (phase_q == PH_DATA) && (rd_ptr_q != commit_ptr_q);
    assign rxs_tvalid = !sys_rst && (phase_q == PH_STS) && (srd_ptr_q != swr_ptr_q);
    assign rxd_hs     = rxd_tvalid && rxd_tready;
    assign rxs_hs     = rxs_tvalid && rxs_tready;
    assign rd_last    = rxd_hs && rxd_tlast;
    assign data_afull = data_afull_q;
    assign sts_afull  = sts_afull_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign drop_cnt   = drop_cnt_q;

    always_comb begin
        data_occ  = wr_ptr_q - rd_ptr_q;
        sts_occ   = swr_ptr_q - srd_ptr_q;
        data_full = data_occ[C_DATA_AW];
        sts_full  = sts_occ[C_STS_AW];
        data_we   = data_wren && !data_full;
        sts_we    = sts_wren && !sts_full;
        // A last beat that itself hits a full FIFO poisons its own frame.
        ovf_now   = ovf_q || data_full;
        commit    = data_wren && data_wlast && data_wgood && !ovf_now;
        drop      = data_wren && data_wlast && !(data_wgood && !ovf_now);

        wr_ptr_d = wr_ptr_q;
        if (drop)
            wr_ptr_d = commit_ptr_q;
        else if (data_we)
            wr_ptr_d = wr_ptr_q + D_ONE;
        commit_ptr_d = commit ? (wr_ptr_q + D_ONE) : commit_ptr_q;
        rd_ptr_d     = rxd_hs ? (rd_ptr_q + D_ONE) : rd_ptr_q;

        ovf_d = ovf_q;
        if (drop)
            ovf_d = 1'b0;
        else if (data_wren && data_full)
            ovf_d = 1'b1;

        pkt_cnt_d = pkt_cnt_q;
        if (commit && !rd_last)
            pkt_cnt_d = pkt_cnt_q + D_ONE;
        else if (!commit && rd_last)
            pkt_cnt_d = pkt_cnt_q - D_ONE;

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;

        swr_ptr_d = sts_we ? (swr_ptr_q + S_ONE) : swr_ptr_q;
        srd_ptr_d = rxs_hs ? (srd_ptr_q + S_ONE) : srd_ptr_q;

        data_afull_d = 32'(data_occ) >= C_DATA_AFULL;
        sts_afull_d  = 32'(sts_occ) >= C_STS_AFULL;

        phase_d = phase_q;
        if ((phase_q == PH_STS) && rxs_hs && rxs_tlast)
            phase_d = PH_DATA;
        else if ((phase_q == PH_DATA) && rd_last)
            phase_d = PH_STS;
    end

    always_ff @(posedge s2mm_clk) begin
        if (data_we)
            dmem[wr_ptr_q[C_DATA_AW-1:0]] <= {data_wlast, data_wkeep, data_wdata};
        if (sts_we)
            smem[swr_ptr_q[C_STS_AW-1:0]] <= {sts_wlast, sts_wkeep, sts_wdata};
    end

    always_ff @(posedge s2mm_clk) begin
        if (sys_rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            swr_ptr_q    <= '0;
            srd_ptr_q    <= '0;
            ovf_q        <= 1'b0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            data_afull_q <= 1'b0;
            sts_afull_q  <= 1'b0;
            phase_q      <= PH_RESET;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            swr_ptr_q    <= swr_ptr_d;
            srd_ptr_q    <= srd_ptr_d;
            ovf_q        <= ovf_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            data_afull_q <= data_afull_d;
            sts_afull_q  <= sts_afull_d;
            phase_q      <= phase_d;
        end
    end
endmodule

// File: tb/tb_rx_pkt_pair_fifo.sv
// tb/tb_rx_pkt_pair_fifo.sv - scoreboard bench for rx_pkt_pair_fifo (defaults, small-depth overflow, data-first)
module tb_rx_pkt_pair_fifo;
    typedef struct packed {
        logic        s;
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] d_wdata [3];
    logic [7:0]  d_wkeep [3];
    logic        d_wlast [3], d_wgood [3], d_wren [3], d_afull [3];
    logic [31:0] s_wdata [3];
    logic [3:0]  s_wkeep [3];
    logic        s_wlast [3], s_wren [3], s_afull [3];
    logic [63:0] rxd_tdata [3];
    logic [7:0]  rxd_tkeep [3];
    logic        rxd_tlast [3], rxd_tvalid [3], rxd_tready [3];
    logic [31:0] rxs_tdata [3];
    logic [3:0]  rxs_tkeep [3];
    logic        rxs_tlast [3], rxs_tvalid [3], rxs_tready [3];
    logic [9:0]  pc0, pc2;
    logic [4:0]  pc1;
    logic [15:0] drop_cnt [3];

    beat_t q0[$];
    beat_t q2[$];
    int n_total = 0, n_pass = 0;
    int excl_viol = 0, order_viol0 = 0, order_viol2 = 0, vis1 = 0;

    rx_pkt_pair_fifo u0 (
        .s2mm_clk(clk), .sys_rst(rst),
        .data_wdata(d_wdata[0]), .data_wkeep(d_wkeep[0]), .data_wlast(d_wlast[0]),
        .data_wgood(d_wgood[0]), .data_wren(d_wren[0]), .data_afull(d_afull[0]),
        .sts_wdata(s_wdata[0]), .sts_wkeep(s_wkeep[0]), .sts_wlast(s_wlast[0]),
        .sts_wren(s_wren[0]), .sts_afull(s_afull[0]),
        .rxd_tdata(rxd_tdata[0]), .rxd_tkeep(rxd_tkeep[0]), .rxd_tlast(rxd_tlast[0]),
        .rxd_tvalid(rxd_tvalid[0]), .rxd_tready(rxd_tready[0]),
        .rxs_tdata(rxs_tdata[0]), .rxs_tkeep(rxs_tkeep[0]), .rxs_tlast(rxs_tlast[0]),
        .rxs_tvalid(rxs_tvalid[0]), .rxs_tready(rxs_tready[0]),
        .pkt_cnt(pc0), .drop_cnt(drop_cnt[0])
    );

    rx_pkt_pair_fifo #(.C_DATA_AW(4), .C_DATA_AFULL(12), .C_STS_FIRST(0)) u1 (
        .s2mm_clk(clk), .sys_rst(rst),
        .data_wdata(d_wdata[1]), .data_wkeep(d_wkeep[1]), .data_wlast(d_wlast[1]),
        .data_wgood(d_wgood[1]), .data_wren(d_wren[1]), .data_afull(d_afull[1]),
        .sts_wdata(s_wdata[1]), .sts_wkeep(s_wkeep[1]), .sts_wlast(s_wlast[1]),
        .sts_wren(s_wren[1]), .sts_afull(s_afull[1]),
        .rxd_tdata(rxd_tdata[1]), .rxd_tkeep(rxd_tkeep[1]), .rxd_tlast(rxd_tlast[1]),
        .rxd_tvalid(rxd_tvalid[1]), .rxd_tready(rxd_tready[1]),
        .rxs_tdata(rxs_tdata[1]), .rxs_tkeep(rxs_tkeep[1]), .rxs_tlast(rxs_tlast[1]),
        .rxs_tvalid(rxs_tvalid[1]), .rxs_tready(rxs_tready[1]),
        .pkt_cnt(pc1), .drop_cnt(drop_cnt[1])
    );

    rx_pkt_pair_fifo #(.C_STS_FIRST(0)) u2 (
        .s2mm_clk(clk), .sys_rst(rst),
        .data_wdata(d_wdata[2]), .data_wkeep(d_wkeep[2]), .data_wlast(d_wlast[2]),
        .data_wgood(d_wgood[2]), .data_wren(d_wren[2]), .data_afull(d_afull[2]),
        .sts_wdata(s_wdata[2]), .sts_wkeep(s_wkeep[2]), .sts_wlast(s_wlast[2]),
        .sts_wren(s_wren[2]), .sts_afull(s_afull[2]),
        .rxd_tdata(rxd_tdata[2]), .rxd_tkeep(rxd_tkeep[2]), .rxd_tlast(rxd_tlast[2]),
        .rxd_tvalid(rxd_tvalid[2]), .rxd_tready(rxd_tready[2]),
        .rxs_tdata(rxs_tdata[2]), .rxs_tkeep(rxs_tkeep[2]), .rxs_tlast(rxs_tlast[2]),
        .rxs_tvalid(rxs_tvalid[2]), .rxs_tready(rxs_tready[2]),
        .pkt_cnt(pc2), .drop_cnt(drop_cnt[2])
    );

    task automatic check(string name, logic [79:0] act, logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic push(int i, beat_t b);
        if (i == 0) q0.push_back(b);
        else q2.push_back(b);
    endtask

    task automatic wr_d(int i, logic [63:0] d, logic [7:0] k, logic last, logic good);
        d_wdata[i] = d; d_wkeep[i] = k; d_wlast[i] = last; d_wgood[i] = good; d_wren[i] = 1'b1;
        @(posedge clk); #1;
        d_wren[i] = 1'b0; d_wlast[i] = 1'b0;
    endtask

    task automatic wr_s(int i, logic [31:0] d, logic do_push);
        if (do_push) push(i, {1'b1, 1'b1, 8'h0F, 32'h0, d});
        s_wdata[i] = d; s_wkeep[i] = 4'hF; s_wlast[i] = 1'b1; s_wren[i] = 1'b1;
        @(posedge clk); #1;
        s_wren[i] = 1'b0;
    endtask

    task automatic frame(int i, int n, logic [63:0] base, logic good);
        for (int j = 0; j < n; j++) begin
            logic       last = (j == n - 1);
            logic [7:0] k    = last ? 8'h0F : 8'hFF;
            if (good) push(i, {1'b0, last, k, base + 64'(j)});
            wr_d(i, base + 64'(j), k, last, last ? good : 1'b1);
        end
    endtask

    task automatic drain(int i, string name);
        int n = 0;
        while (((i == 0) ? q0.size() : q2.size()) != 0 && n < 200) begin
            @(posedge clk); n++;
        end
        @(posedge clk); #1;
        check(name, (i == 0) ? q0.size() : q2.size(), 0);
    endtask

    always @(negedge clk) begin : mon0
        beat_t a, e;
        if (!rst) begin
            if (rxd_tvalid[0] && rxs_tvalid[0]) excl_viol++;
            if (rxs_tvalid[0] && (q0.size() == 0 || !q0[0].s)) order_viol0++;
            if (rxd_tvalid[0] && (q0.size() == 0 || q0[0].s)) order_viol0++;
            if (rxs_tvalid[0] && rxs_tready[0] && q0.size() != 0 && q0[0].s) begin
                a = {1'b1, rxs_tlast[0], 4'h0, rxs_tkeep[0], 32'h0, rxs_tdata[0]};
                e = q0.pop_front();
                check("rxs0_beat", a, e);
            end
            if (rxd_tvalid[0] && rxd_tready[0] && q0.size() != 0 && !q0[0].s) begin
                a = {1'b0, rxd_tlast[0], rxd_tkeep[0], rxd_tdata[0]};
                e = q0.pop_front();
                check("rxd0_beat", a, e);
            end
        end
    end

    always @(negedge clk) begin : mon2
        beat_t a, e;
        if (!rst) begin
            if (rxd_tvalid[2] && rxs_tvalid[2]) excl_viol++;
            if (rxs_tvalid[2] && (q2.size() == 0 || !q2[0].s)) order_viol2++;
            if (rxd_tvalid[2] && (q2.size() == 0 || q2[0].s)) order_viol2++;
            if (rxs_tvalid[2] && rxs_tready[2] && q2.size() != 0 && q2[0].s) begin
                a = {1'b1, rxs_tlast[2], 4'h0, rxs_tkeep[2], 32'h0, rxs_tdata[2]};
                e = q2.pop_front();
                check("rxs2_beat", a, e);
            end
            if (rxd_tvalid[2] && rxd_tready[2] && q2.size() != 0 && !q2[0].s) begin
                a = {1'b0, rxd_tlast[2], rxd_tkeep[2], rxd_tdata[2]};
                e = q2.pop_front();
                check("rxd2_beat", a, e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (rxd_tvalid[1] || rxs_tvalid[1])) vis1++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_wdata[i] = '0; d_wkeep[i] = '0; d_wlast[i] = 1'b0; d_wgood[i] = 1'b0; d_wren[i] = 1'b0;
            s_wdata[i] = '0; s_wkeep[i] = '0; s_wlast[i] = 1'b0; s_wren[i] = 1'b0;
            rxd_tready[i] = 1'b0; rxs_tready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_rxd_tvalid", rxd_tvalid[i], 0);
            check("rst_rxs_tvalid", rxs_tvalid[i], 0);
            check("rst_data_afull", d_afull[i], 0);
            check("rst_sts_afull", s_afull[i], 0);
            check("rst_drop_cnt", drop_cnt[i], 0);
        end
        check("rst_pkt_cnt0", pc0, 0);
        check("rst_pkt_cnt1", pc1, 0);
        check("rst_pkt_cnt2", pc2, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Status first: status beat, then 4-beat frame held until both readies open.
        wr_s(0, 32'hA001, 1'b1);
        frame(0, 4, 64'h100, 1'b1);
        @(posedge clk); #1;
        check("sts_first_pkt1", pc0, 1);
        check("sts_first_rxd_hold", rxd_tvalid[0], 0);
        rxs_tready[0] = 1'b1; rxd_tready[0] = 1'b1;
        drain(0, "sts_first_drain");
        check("sts_first_pkt0", pc0, 0);

        // Bad frame dropped, following good frame delivered.
        frame(0, 3, 64'h200, 1'b0);
        wr_s(0, 32'hA002, 1'b1);
        frame(0, 2, 64'h300, 1'b1);
        drain(0, "drop_drain");
        check("drop_cnt", drop_cnt[0], 1);

        // Frame B's last-beat commit coincides with frame A's tlast handshake.
        rxd_tready[0] = 1'b0;
        wr_s(0, 32'hA003, 1'b1);
        frame(0, 1, 64'h400, 1'b1);
        n = 0;
        while (!rxd_tvalid[0] && n < 20) begin @(posedge clk); #1; n++; end
        check("same_a_visible", rxd_tvalid[0], 1);
        wr_s(0, 32'hA004, 1'b1);
        push(0, {1'b0, 1'b0, 8'hFF, 64'h500});
        wr_d(0, 64'h500, 8'hFF, 1'b0, 1'b1);
        rxd_tready[0] = 1'b1;
        push(0, {1'b0, 1'b1, 8'h0F, 64'h501});
        wr_d(0, 64'h501, 8'h0F, 1'b1, 1'b1);
        rxd_tready[0] = 1'b0;
        check("same_pkt_hold", pc0, 1);
        check("same_b_committed", u0.commit_ptr_q - u0.rd_ptr_q, 2);
        rxd_tready[0] = 1'b1;
        drain(0, "same_drain");
        check("same_pkt0", pc0, 0);

        // 20-beat frame into a 16-deep FIFO with no reader.
        for (int j = 1; j <= 20; j++) begin
            wr_d(1, 64'(j), 8'hFF, (j == 20), 1'b1);
            if (j == 12) check("ovf_afull_below", d_afull[1], 0);
            if (j == 13) check("ovf_afull_at", d_afull[1], 1);
        end
        check("ovf_drop_cnt", drop_cnt[1], 1);
        check("ovf_pkt_cnt", pc1, 0);
        check("ovf_wr_ptr", u1.wr_ptr_q, 0);
        check("ovf_commit_ptr", u1.commit_ptr_q, 0);
        @(posedge clk); #1;
        check("ovf_afull_clear", d_afull[1], 0);
        check("ovf_rxd_tvalid", rxd_tvalid[1], 0);

        // Data first: status written early must wait for the data tlast handshake.
        wr_s(2, 32'hB001, 1'b0);
        frame(2, 3, 64'h600, 1'b1);
        push(2, {1'b1, 1'b1, 8'h0F, 32'h0, 32'hB001});
        rxs_tready[2] = 1'b1; rxd_tready[2] = 1'b1;
        drain(2, "data_first_drain");

        // Reset in mid-frame, then a clean 1-beat frame.
        wr_d(0, 64'h700, 8'hFF, 1'b0, 1'b1);
        wr_d(0, 64'h701, 8'hFF, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_rxd_tvalid", rxd_tvalid[0], 0);
        check("mid_rst_rxs_tvalid", rxs_tvalid[0], 0);
        check("mid_rst_pkt_cnt", pc0, 0);
        check("mid_rst_drop_cnt", drop_cnt[0], 0);
        check("mid_rst_data_afull", d_afull[0], 0);
        rst = 1'b0;
        wr_s(0, 32'hA005, 1'b1);
        frame(0, 1, 64'h800, 1'b1);
        drain(0, "mid_rst_drain");
        check("mid_rst_pkt0", pc0, 0);

        check("phase_exclusive", excl_viol, 0);
        check("order0", order_viol0, 0);
        check("order2", order_viol2, 0);
        check("ovf_nothing_visible", vis1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
